imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the decode stage. Accepts one
//  instruction per cycle over a valid/ready handshake and produces the sign-extended
//  XLEN-bit immediate, a format code and an illegal flag through a 2-entry output
//  buffer. Covers all RV32I/RV64I immediate formats. Counts illegal opcodes.
// PARAMETERS
//  XLEN        32  immediate/output width; legal values 32 or 64
//  SHAMT_ZEXT  1   1: OP-IMM(-32) shifts (funct3 001/101) give zero-extended shamt
//  CNT_W       8   width of the saturating illegal-opcode counter
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous active-low reset
//  in_valid     in   1     in_insn valid
//  in_ready     out  1     buffer can accept (combinational from state only)
//  in_insn      in   32    instruction word
//  out_valid    out  1     out_* hold a result
//  out_ready    in   1     consumer takes result this cycle
//  out_imm      out  XLEN  sign/zero-extended immediate
//  out_fmt      out  3     0 NONE(R), 1 I, 2 S, 3 B, 4 U, 5 J, 7 ILLEGAL
//  out_illegal  out  1     opcode not recognised
//  cnt_clr      in   1     synchronous clear of illegal_cnt
//  illegal_cnt  out  CNT_W accepted illegal instructions, saturating
// BEHAVIOUR
//  Decode (opcode=in_insn[6:0]), s=in_insn[31], ext to XLEN with s:
//  - I: 0000011, 0010011, 1100111, and 0011011 when XLEN=64 -> {s..,insn[30:20]}
//  - shamt: SHAMT_ZEXT=1, opcode 0010011/0011011, funct3 001/101 -> zero-ext
//    insn[25:20] (XLEN=64, 0010011) else insn[24:20]; fmt stays I
//  - S: 0100011 -> {s..,insn[30:25],insn[11:7]}
//  - B: 1100011 -> {s..,insn[7],insn[30:25],insn[11:8],1'b0}
//  - U: 0110111, 0010111 -> {s..,insn[31:12],12'b0}
//  - J: 1101111 -> {s..,insn[19:12],insn[20],insn[30:21],1'b0}
//  - NONE: 0110011, 1110011, 0001111, 0111011(XLEN=64 only) -> imm 0, fmt 0
//  - anything else -> imm 0, fmt 7, out_illegal 1 (never X)
//  Buffer: 2-entry FIFO, occupancy count 0..2.
//  - in_ready = (count != 2); push when in_valid && in_ready
//  - out_valid = (count != 0); out_* = head entry; pop when out_valid && out_ready
//  - push at edge N into empty buffer -> out_valid=1 after edge N (latency 1)
//  - push and pop same edge: count unchanged, order preserved
//  - full: in_ready=0 even if out_ready=1 (no combinational pass-through)
//  - out_* stable while out_valid && !out_ready; in_insn changes while
//    in_ready=0 have no effect
//  - pointers wrap modulo 2
//  Counter: on push of illegal insn, illegal_cnt+1, saturating at 2^CNT_W-1.
//  - cnt_clr has priority: cnt_clr with illegal push same edge -> illegal_cnt=1;
//    without illegal push -> 0
//  Reset (rst_n=0, any time): count=0, pointers=0, out_valid=0, out_imm=0,
//  out_fmt=0, out_illegal=0, illegal_cnt=0; buffered entries discarded; in_ready=1
//  from the first edge after rst_n deasserts.
//  out_* = 0 whenever out_valid=0.
// TESTING
//  1 XLEN=32: push 0xFFC10083 (lb, imm -4), out_ready=1 -> next cycle out_imm=
//    0xFFFFFFFC, fmt=1; push 0xFE000EE3 (beq, -4) -> out_imm=0xFFFFFFFC, fmt=3
//  2 XLEN=64: push 0x800000EF (jal, -1MiB) -> out_imm=0xFFFFFFFFFFF00000, fmt=5;
//    push 0x03F01013 (slli 63) -> out_imm=63, fmt=1; 0x123450B7 lui ->
//    imm=0x0000000012345000, fmt=4
//  3 out_ready=0, push 3 insns back-to-back -> in_ready drops after 2nd accept;
//    3rd held; release out_ready -> 3 results in order, none lost or duplicated
//  4 push 0x0000007F (opcode 1111111) x3 with CNT_W=2 -> fmt=7, illegal=1,
//    imm=0, illegal_cnt 1,2,3, 4th stays 3; cnt_clr with 5th illegal -> 1
//  5 fill buffer (count=2), assert rst_n=0 mid-cycle -> out_valid=0, all
//    outputs 0 immediately; after release first push reappears after 1 cycle
//  6 random stream, random out_ready: compare against reference decode model,
//    check stability of out_* while stalled

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: a combinational RV32I/RV64I immediate decode
// feeding a 2-entry output FIFO, plus a saturating counter of accepted illegal opcodes.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int SHAMT_ZEXT = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [2:0] FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  ent_t       w_ent;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_s;
  logic       w_push, w_pop;

  ent_t             r_buf [2];
  logic             r_wptr, r_rptr;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_icnt;

  assign w_op = in_insn[6:0];
  assign w_f3 = in_insn[14:12];
  assign w_s  = in_insn[31];

  always_comb begin
    w_ent.imm = '0;
    w_ent.fmt = FMT_ILL;
    w_ent.ill = 1'b1;
    case (w_op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011: begin
        if (w_op != 7'b0011011 || XLEN == 64) begin
          w_ent.fmt = FMT_I;
          w_ent.ill = 1'b0;
          w_ent.imm = {{(XLEN-11){w_s}}, in_insn[30:20]};
          // Shift-immediates carry an unsigned shamt; RV64 OP-IMM uses 6 bits.
          if (SHAMT_ZEXT != 0 && w_op != 7'b0000011 && w_op != 7'b1100111 &&
              (w_f3 == 3'b001 || w_f3 == 3'b101)) begin
            if (XLEN == 64 && w_op == 7'b0010011)
              w_ent.imm = {{(XLEN-6){1'b0}}, in_insn[25:20]};
            else
              w_ent.imm = {{(XLEN-5){1'b0}}, in_insn[24:20]};
          end
        end
      end
      7'b0100011: begin
        w_ent.fmt = FMT_S;
        w_ent.ill = 1'b0;
        w_ent.imm = {{(XLEN-11){w_s}}, in_insn[30:25], in_insn[11:7]};
      end
      7'b1100011: begin
        w_ent.fmt = FMT_B;
        w_ent.ill = 1'b0;
        w_ent.imm = {{(XLEN-12){w_s}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_ent.fmt = FMT_U;
        w_ent.ill = 1'b0;
        w_ent.imm = {{(XLEN-31){w_s}}, in_insn[30:12], 12'b0};
      end
      7'b1101111: begin
        w_ent.fmt = FMT_J;
        w_ent.ill = 1'b0;
        w_ent.imm = {{(XLEN-20){w_s}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
      end
      7'b0110011, 7'b1110011, 7'b0001111, 7'b0111011: begin
        if (w_op != 7'b0111011 || XLEN == 64) begin
          w_ent.fmt = FMT_NONE;
          w_ent.ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Ready depends only on occupancy, so a full buffer never passes through.
  assign in_ready    = (r_cnt != 2'd2);
  assign out_valid   = (r_cnt != 2'd0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign out_imm     = out_valid ? r_buf[r_rptr].imm : '0;
  assign out_fmt     = out_valid ? r_buf[r_rptr].fmt : '0;
  assign out_illegal = out_valid ? r_buf[r_rptr].ill : 1'b0;
  assign illegal_cnt = r_icnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_icnt <= '0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wptr] <= w_ent;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
      // Clear wins, but an illegal insn accepted on the same edge still counts.
      if (cnt_clr)
        r_icnt <= (w_push && w_ent.ill) ? CNT_W'(1) : '0;
      else if (w_push && w_ent.ill && r_icnt != CNT_MAX)
        r_icnt <= r_icnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: an RV32 (2-bit counter) and an RV64 instance share one stimulus
// stream; expected results come from an arithmetic reference decode.
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [31:0] in_insn = '0;

  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [1:0]  cnt32;
  logic [7:0]  cnt64;

  exp_t q32[$], q64[$];
  int   mcnt = 0, c32 = 0, c64 = 0;
  int   n_vec = 0, n_err = 0;

  imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1), .CNT_W(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .in_insn(in_insn),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .cnt_clr(cnt_clr), .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1), .CNT_W(8)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_insn(in_insn),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .cnt_clr(cnt_clr), .illegal_cnt(cnt64));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference decode straight from the format tables, via signed arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] insn, input int xlen);
    exp_t   e;
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    bit rv64;
    op = insn[6:0];
    f3 = insn[14:12];
    rv64 = (xlen == 64);
    v = 0;
    e.fmt = 3'd7;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67 || (rv64 && op == 7'h1B)) begin
      e.fmt = 3'd1;
      v = longint'($signed(insn[31:20]));
      if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5))
        v = (rv64 && op == 7'h13) ? longint'(insn[25:20]) : longint'(insn[24:20]);
    end else if (op == 7'h23) begin
      e.fmt = 3'd2;
      v = longint'($signed({insn[31:25], insn[11:7]}));
    end else if (op == 7'h63) begin
      e.fmt = 3'd3;
      v = longint'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
    end else if (op == 7'h37 || op == 7'h17) begin
      e.fmt = 3'd4;
      v = longint'($signed({insn[31:12], 12'b0}));
    end else if (op == 7'h6F) begin
      e.fmt = 3'd5;
      v = longint'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
    end else if (op == 7'h33 || op == 7'h73 || op == 7'h0F || (rv64 && op == 7'h3B)) begin
      e.fmt = 3'd0;
    end
    e.ill = (e.fmt == 3'd7);
    e.imm = rv64 ? v : {32'b0, v[31:0]};
    return e;
  endfunction

  // Issue side: model occupancy and counters, push expected results on acceptance.
  logic issue_push, issue_pop;
  exp_t e32, e64;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("in_ready32", rdy32, mcnt != 2);
      chk("in_ready64", rdy64, mcnt != 2);
      chk("illegal_cnt32", cnt32, c32);
      chk("illegal_cnt64", cnt64, c64);
      issue_push = in_valid && (mcnt != 2);
      issue_pop  = (mcnt != 0) && out_ready;
      e32 = ref_dec(in_insn, 32);
      e64 = ref_dec(in_insn, 64);
      if (issue_push) begin
        q32.push_back(e32);
        q64.push_back(e64);
      end
      if (cnt_clr) c32 = (issue_push && e32.ill) ? 1 : 0;
      else if (issue_push && e32.ill && c32 < 3) c32++;
      if (cnt_clr) c64 = (issue_push && e64.ill) ? 1 : 0;
      else if (issue_push && e64.ill && c64 < 255) c64++;
      mcnt = mcnt + int'(issue_push) - int'(issue_pop);
    end
  end

  // Monitors: the head must be presented (and held while stalled) until taken.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid32", vld32, q32.size() != 0);
      if (q32.size() != 0) begin
        chk("out_imm32", {32'b0, imm32}, q32[0].imm);
        chk("out_fmt32", fmt32, q32[0].fmt);
        chk("out_illegal32", ill32, q32[0].ill);
        if (out_ready) void'(q32.pop_front());
      end else begin
        chk("idle_out32", {28'b0, imm32, fmt32, ill32}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid64", vld64, q64.size() != 0);
      if (q64.size() != 0) begin
        chk("out_imm64", imm64, q64[0].imm);
        chk("out_fmt64", fmt64, q64[0].fmt);
        chk("out_illegal64", ill64, q64[0].ill);
        if (out_ready) void'(q64.pop_front());
      end else begin
        chk("idle_out64", imm64 | {60'b0, fmt64, ill64}, 64'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] insn, input logic ordy, input logic clr);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_insn   = insn;
    out_ready = ordy;
    cnt_clr   = clr;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_valid32", vld32, 0);
    chk("rst_valid64", vld64, 0);
    chk("rst_out32", {26'b0, imm32, fmt32, ill32, cnt32}, 64'd0);
    chk("rst_out64", imm64 | {52'b0, fmt64, ill64, cnt64}, 64'd0);
    q32.delete();
    q64.delete();
    mcnt = 0;
    c32 = 0;
    c64 = 0;
  endtask

  logic [6:0]  ops [16] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                            7'h6F, 7'h33, 7'h73, 7'h0F, 7'h3B, 7'h7F, 7'h13, 7'h00};
  logic [31:0] r;

  initial begin
    #1;
    reset_now();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed: lb/beq -4, jal -1MiB, slli 63, lui.
    drive(1, 32'hFFC10083, 1, 0);
    drive(1, 32'hFE000EE3, 1, 0);
    drive(1, 32'h800000EF, 1, 0);
    drive(1, 32'h03F01013, 1, 0);
    drive(1, 32'h123450B7, 1, 0);
    drive(0, 32'h0, 1, 0);

    // Back-pressure: third insn held, a changed word while stalled is ignored.
    drive(1, 32'h00500093, 0, 0);
    drive(1, 32'h00A12023, 0, 0);
    drive(1, 32'h0000006F, 0, 0);
    drive(1, 32'hFFF00013, 0, 0);
    drive(1, 32'h0000006F, 1, 0);
    drive(1, 32'h0000006F, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // Illegal counter saturation on the 2-bit instance, then clear with a push.
    drive(0, 32'h0, 1, 1);
    repeat (4) drive(1, 32'h0000007F, 1, 0);
    drive(1, 32'h0000007F, 1, 1);
    drive(0, 32'h0, 1, 0);

    // Reset with a full buffer, then a fresh push.
    drive(1, 32'h00100113, 0, 0);
    drive(1, 32'h00200193, 0, 0);
    drive(0, 32'h0, 0, 0);
    @(posedge clk);
    #2;
    reset_now();
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);
    rst_n = 1'b1;
    drive(1, 32'hFFC10083, 1, 0);
    drive(0, 32'h0, 1, 0);

    // Random stream with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      drive($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 15)]},
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    repeat (6) drive(0, 32'h0, 1, 0);
    @(negedge clk);
    #2;
    chk("drain32", q32.size(), 0);
    chk("drain64", q64.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
